spi_stream_monitor: RTL

- Frame-aware monitor on the output of the SPI receiver (data word, data-valid, final-pixel flag), for board-level link bring-up.
- Per frame: counts words, builds a checksum, checks length against an expected value, and detects mid-frame stalls.
- Drives a selectable 32-bit value for the seven-segment controller, a status RGB code and sticky error flags.
- Generalises the single-byte display path to any word width, with frame statistics and selectable display modes.

---
 rtl/spi_mon_pkg.sv | 15 +
 rtl/spi_mon_frame_stats.sv | 92 +++++++++
 rtl/spi_stream_monitor.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/spi_mon_pkg.sv
// Shared types and constants for the SPI stream monitor.
package spi_mon_pkg;

    typedef enum logic [0:0] {IDLE, ACTIVE} mon_state_t;
    typedef enum logic [1:0] {MODE_WORD, MODE_LEN, MODE_CNT_SUM, MODE_MINMAX} mon_mode_t;

    localparam logic [2:0] RGB_OFF  = 3'b000;
    localparam logic [2:0] RGB_DATA = 3'b010;
    localparam logic [2:0] RGB_LAST = 3'b101;
    localparam logic [2:0] RGB_ERR  = 3'b100;

    localparam int SUM_WIDTH  = 16;
    localparam int FCNT_WIDTH = 16;

endpackage

// File: rtl/spi_mon_frame_stats.sv
// Per-frame word count, checksum and (with SPI_STREAM_MONITOR_MINMAX_EN) min/max,
// latched into last_* on commit.
module spi_mon_frame_stats
    import spi_mon_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 20
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  acc,
    input  logic                  start,
    input  logic                  commit,
    input  logic                  clear,
    output logic [CNT_WIDTH-1:0]  len_nxt,
    output logic [CNT_WIDTH-1:0]  last_len,
    output logic [SUM_WIDTH-1:0]  last_sum
`ifdef SPI_STREAM_MONITOR_MINMAX_EN
    ,
    output logic [DATA_WIDTH-1:0] last_min,
    output logic [DATA_WIDTH-1:0] last_max
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [SUM_WIDTH-1:0] sum_q, sum_d;

    always_comb begin
        cnt_d = cnt_q;
        sum_d = sum_q;
        if (acc) begin
            if (start) begin
                cnt_d = CNT_WIDTH'(1);
                sum_d = SUM_WIDTH'(data);
            end else begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                sum_d = sum_q + SUM_WIDTH'(data);
            end
        end
    end

    assign len_nxt = cnt_d;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q    <= '0;
            sum_q    <= '0;
            last_len <= '0;
            last_sum <= '0;
        end else begin
            cnt_q <= clear ? '0 : cnt_d;
            sum_q <= clear ? '0 : sum_d;
            if (commit) begin
                last_len <= cnt_d;
                last_sum <= sum_d;
            end
        end
    end

`ifdef SPI_STREAM_MONITOR_MINMAX_EN
    logic [DATA_WIDTH-1:0] min_q, min_d, max_q, max_d;

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (acc) begin
            min_d = (start || data < min_q) ? data : min_q;
            max_d = (start || data > max_q) ? data : max_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            min_q    <= '0;
            max_q    <= '0;
            last_min <= '0;
            last_max <= '0;
        end else begin
            min_q <= clear ? '0 : min_d;
            max_q <= clear ? '0 : max_d;
            if (commit) begin
                last_min <= min_d;
                last_max <= max_d;
            end
        end
    end
`endif

endmodule

// File: rtl/spi_stream_monitor.sv
// Frame-aware monitor for the SPI receiver output: frame FSM, stall timeout,
// display mux and sticky errors. Mode 3 min/max needs SPI_STREAM_MONITOR_MINMAX_EN.
//
// state  | meaning
// IDLE   | between frames; next accepted word starts a frame
// ACTIVE | inside a frame; waiting for the final word or a stall timeout
module spi_stream_monitor
    import spi_mon_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int EXP_PIXELS     = 4800,
    parameter int CNT_WIDTH      = 20,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    input  logic                  final_pixel_in,
    input  logic [1:0]            mode_in,
    input  logic                  clr_err_in,
    output logic [31:0]           val_out,
    output logic                  frame_done_out,
    output logic                  len_err_out,
    output logic                  timeout_err_out,
    output logic [2:0]            rgb_out
);

    localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_RELOAD = IDLE_W'(TIMEOUT_CYCLES - 1);

    mon_state_t            state_q, state_d;
    logic                  start, commit, abort;
    logic [IDLE_W-1:0]     idle_q;
    logic [CNT_WIDTH-1:0]  len_nxt, last_len;
    logic [SUM_WIDTH-1:0]  last_sum;
    logic [FCNT_WIDTH-1:0] frame_cnt_q;
    logic [DATA_WIDTH-1:0] last_word_q;
    logic [2:0]            rgb_word_q;
    logic [31:0]           val_q, val_d;
    logic                  done_q, len_err_q, to_err_q, len_set;
`ifdef SPI_STREAM_MONITOR_MINMAX_EN
    logic [DATA_WIDTH-1:0] last_min, last_max;
`endif

    spi_mon_frame_stats #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_stats (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .data     (data_in),
        .acc      (data_valid_in),
        .start    (start),
        .commit   (commit),
        .clear    (abort),
        .len_nxt  (len_nxt),
        .last_len (last_len),
        .last_sum (last_sum)
`ifdef SPI_STREAM_MONITOR_MINMAX_EN
        ,
        .last_min (last_min),
        .last_max (last_max)
`endif
    );

    // Idle timer is a down-counter reloaded by every word; expiry at zero.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        commit  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_valid_in) begin
                    start = 1'b1;
                    if (final_pixel_in) commit  = 1'b1;
                    else                state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (data_valid_in) begin
                    if (final_pixel_in) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (idle_q == '0) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign len_set = commit && (len_nxt != CNT_WIDTH'(EXP_PIXELS));

    always_comb begin
        val_d = 32'h0;
        case (mon_mode_t'(mode_in))
            MODE_WORD:    val_d = 32'(last_word_q);
            MODE_LEN:     val_d = 32'(last_len);
            MODE_CNT_SUM: val_d = {frame_cnt_q, last_sum};
`ifdef SPI_STREAM_MONITOR_MINMAX_EN
            MODE_MINMAX:  val_d = {16'(last_max), 16'(last_min)};
`else
            MODE_MINMAX:  val_d = 32'h0;
`endif
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            idle_q      <= '0;
            frame_cnt_q <= '0;
            last_word_q <= '0;
            rgb_word_q  <= RGB_OFF;
            val_q       <= '0;
            done_q      <= 1'b0;
            len_err_q   <= 1'b0;
            to_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (data_valid_in)
                idle_q <= IDLE_RELOAD;
            else if (abort)
                idle_q <= '0;
            else if (state_q == ACTIVE && idle_q != '0)
                idle_q <= idle_q - IDLE_W'(1);
            if (commit)
                frame_cnt_q <= frame_cnt_q + FCNT_WIDTH'(1);
            if (data_valid_in) begin
                last_word_q <= data_in;
                rgb_word_q  <= final_pixel_in ? RGB_LAST : RGB_DATA;
            end
            val_q     <= val_d;
            done_q    <= commit;
            len_err_q <= len_set | (len_err_q & ~clr_err_in);
            to_err_q  <= abort   | (to_err_q  & ~clr_err_in);
        end
    end

    assign val_out         = val_q;
    assign frame_done_out  = done_q;
    assign len_err_out     = len_err_q;
    assign timeout_err_out = to_err_q;
    assign rgb_out         = (len_err_q || to_err_q) ? RGB_ERR : rgb_word_q;

endmodule
